// File: rtl/xbus_copy_master_pkg.sv
// Shared bus geometry for the select-based peripheral bus: widths, region
// bases and a helper to classify an address into the unmapped hole.
package xbus_copy_master_pkg;

    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 10;

    // Low address bits decoded inside one select region; the bits above
    // them pick the region.
    localparam int SEL_ADDR_W = 11;

    localparam logic [ADDR_W-1:0] MEM_BASE  = 13'h0000;
    localparam logic [ADDR_W-1:0] IO_BASE   = 13'h0800;
    localparam logic [ADDR_W-1:0] HOLE_BASE = 13'h1000;
    localparam logic [ADDR_W-1:0] ROM_BASE  = 13'h1800;

    // True when the address falls in the region the decoder traps on.
    function automatic logic in_hole(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:SEL_ADDR_W] == HOLE_BASE[ADDR_W-1:SEL_ADDR_W];
    endfunction

endpackage

// File: rtl/xbus_copy_master_if.sv
// Select-based peripheral bus as seen between one initiator and the
// address decoder.
interface xbus_copy_master_if #(
    parameter int ADDR_W = xbus_copy_master_pkg::ADDR_W,
    parameter int DATA_W = xbus_copy_master_pkg::DATA_W
);

    logic [ADDR_W-1:0] addr;
    logic              sel;
    logic              we;
    logic [DATA_W-1:0] data_to_wr;
    logic [DATA_W-1:0] data_to_rd;
    logic              trap;

    modport master (
        output addr, sel, we, data_to_wr,
        input  data_to_rd, trap
    );

    modport slave (
        input  addr, sel, we, data_to_wr,
        output data_to_rd, trap
    );

endinterface

// File: rtl/xbus_copy_master.sv
// Block-copy bus initiator: copies len words from src_addr to dst_addr,
// one read -> capture -> write sequence per word, aborting on a decoder trap.
module xbus_copy_master #(
    parameter int ADDR_W = xbus_copy_master_pkg::ADDR_W,
    parameter int DATA_W = xbus_copy_master_pkg::DATA_W,
    parameter int LEN_W  = xbus_copy_master_pkg::LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               err,
    xbus_copy_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;

    // Sequencer: every bus output is loaded on the edge that enters the
    // state it belongs to, so the bus sees only flop outputs. data_to_wr
    // doubles as the word buffer between the read and the write.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled inside the clocked block, so a transfer in
        // flight is dropped at the very edge rst_n is seen low.
        if (!rst_n) begin
            state          <= ST_IDLE;
            src_ptr        <= '0;
            dst_ptr        <= '0;
            remaining      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            bus.addr       <= '0;
            bus.sel        <= 1'b0;
            bus.we         <= 1'b0;
            bus.data_to_wr <= {DATA_W{1'b0}};
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge value of state, pointers and counter.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (len != '0) begin
                            src_ptr   <= src_addr;
                            dst_ptr   <= dst_addr;
                            remaining <= len;
                            bus.addr  <= src_addr;
                            bus.sel   <= 1'b1;
                            bus.we    <= 1'b0;
                            state     <= ST_RD;
                        end else begin
                            // Empty copy: report completion without touching the bus.
                            state <= ST_FIN;
                        end
                    end
                end

                ST_RD: begin
                    bus.sel <= 1'b0;
                    if (bus.trap) begin
                        err   <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        state <= ST_CAP;
                    end
                end

                ST_CAP: begin
                    bus.data_to_wr <= bus.data_to_rd;
                    bus.addr       <= dst_ptr;
                    bus.sel        <= 1'b1;
                    bus.we         <= 1'b1;
                    state          <= ST_WR;
                end

                ST_WR: begin
                    bus.sel <= 1'b0;
                    bus.we  <= 1'b0;
                    if (bus.trap) begin
                        err   <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        // Pointers wrap modulo 2^ADDR_W by construction.
                        src_ptr   <= src_ptr + 1'b1;
                        dst_ptr   <= dst_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_FIN;
                        end else begin
                            bus.addr <= src_ptr + 1'b1;
                            bus.sel  <= 1'b1;
                            state    <= ST_RD;
                        end
                    end
                end

                ST_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_copy_master.sv
// Self-checking bench for xbus_copy_master: a memory-backed decoder model
// answers bus cycles, and a transaction-level copy model predicts bus
// activity, completion timing, error flag and final memory contents.
module tb_xbus_copy_master;
    import xbus_copy_master_pkg::*;

    localparam int AW        = ADDR_W;
    localparam int DW        = DATA_W;
    localparam int LW        = LEN_W;
    localparam int MEM_WORDS = 1 << AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
        int            cyc;
    } bus_ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic          sync_req = 1'b0;

    logic [DW-1:0] mem     [MEM_WORDS];
    logic [DW-1:0] ref_mem [MEM_WORDS];

    int      n_checks = 0;
    int      n_errors = 0;
    bus_ev_t exp_q[$];
    bus_ev_t obs_q[$];
    logic    exp_err;
    int      exp_done;
    int      obs_done;
    int      obs_busy;
    int      obs_we_wo_sel;
    logic    obs_err;
    logic    obs_after_done;
    logic    obs_after_busy;

    xbus_copy_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    xbus_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Decoder model: trap is combinational on the hole region, reads return
    // data the cycle after the select, writes land at the edge.
    assign bus.trap = bus.sel && in_hole(bus.addr);

    always @(posedge clk) begin
        if (sync_req) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_mem[i];
        end else if (bus.sel && !bus.trap) begin
            if (bus.we) mem[bus.addr] <= bus.data_to_wr;
            else        bus.data_to_rd <= mem[bus.addr];
        end
    end

    // Copy the reference memory image into the decoder memory.
    task automatic sync_mem();
        @(negedge clk); sync_req = 1'b1;
        @(negedge clk); sync_req = 1'b0;
    endtask

    // Word-by-word copy semantics: read src+k, write dst+k, stop at the first
    // trapping access. Cycle k of the copy reads at 3k+1 and writes at 3k+3
    // relative to the start cycle; done follows two cycles after the last access.
    task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] w;
        int            last;
        exp_q.delete();
        exp_err = 1'b0;
        last    = 0;
        for (int k = 0; k < int'(n); k++) begin
            ra = s + AW'(k);
            exp_q.push_back('{ra, 1'b0, DW'(0), 3 * k + 1});
            last = 3 * k + 1;
            if (in_hole(ra)) begin exp_err = 1'b1; break; end
            w  = ref_mem[ra];
            wa = d + AW'(k);
            exp_q.push_back('{wa, 1'b1, w, 3 * k + 3});
            last = 3 * k + 3;
            if (in_hole(wa)) begin exp_err = 1'b1; break; end
            ref_mem[wa] = w;
        end
        exp_done = (n == '0) ? 2 : last + 2;
    endtask

    // Number of observed bus cycles that disagree with the model (data only on writes).
    function automatic int ev_diffs();
        int nd = (obs_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].we !== exp_q[i].we ||
                obs_q[i].cyc != exp_q[i].cyc ||
                (exp_q[i].we && obs_q[i].data !== exp_q[i].data)) nd++;
        end
        return nd;
    endfunction

    function automatic int mem_diffs();
        int nd = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) nd++;
        return nd;
    endfunction

    // Pulse start, then log bus/status activity each cycle until done (bounded).
    // Optionally raises a second start with other values at cycle inj_cyc.
    task automatic do_transfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                               input int inj_cyc, input logic [AW-1:0] inj_s, input logic [LW-1:0] inj_n);
        int cyc;
        int budget;
        obs_q.delete();
        obs_done      = -1;
        obs_busy      = 0;
        obs_we_wo_sel = 0;
        obs_err       = 1'b0;
        budget        = 3 * int'(n) + 20;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        cyc = 0;
        while (obs_done < 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.we && !bus.sel) obs_we_wo_sel++;
            if (bus.sel) obs_q.push_back('{bus.addr, bus.we, bus.data_to_wr, cyc});
            if (busy) obs_busy++;
            if (done) begin obs_done = cyc; obs_err = err; end
            if (cyc == inj_cyc) begin
                start = 1'b1; src_addr = inj_s; dst_addr = inj_s + 'h55; len = inj_n;
            end else begin
                start = 1'b0;
            end
        end
        if (obs_done < 0) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: done not seen within %0d cycles", budget);
        end
        @(negedge clk);
        start = 1'b0;
        obs_after_done = done;
        obs_after_busy = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err} !== 3'b000) begin
            n_errors++; $display("FAIL reset_status: got busy/done/err=%b want 000", {busy, done, err});
        end
        n_checks++;
        if ({bus.sel, bus.we} !== 2'b00) begin
            n_errors++; $display("FAIL reset_sel_we: got %b want 00", {bus.sel, bus.we});
        end
        n_checks++;
        if (bus.addr !== '0 || bus.data_to_wr !== '0) begin
            n_errors++; $display("FAIL reset_addr_data: got addr=%h data=%h want 0/0", bus.addr, bus.data_to_wr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [AW-1:0] s = MEM_BASE + 'h10;
        logic [AW-1:0] d = MEM_BASE + 'h40;
        int bad;
        for (int i = 0; i < 4; i++) ref_mem[s + AW'(i)] = DW'(32'hA0 + i);
        sync_mem();
        model_copy(s, d, 4);
        do_transfer(s, d, 4, -1, '0, '0);
        n_checks++;
        if (obs_q.size() != 8) begin n_errors++; $display("FAIL basic_sel_count: got %0d want 8", obs_q.size()); end
        bad = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].we !== 1'(i % 2)) bad++;
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL basic_we_alternate: got %0d bad cycles want 0", bad); end
        n_checks++;
        if (ev_diffs() != 0) begin n_errors++; $display("FAIL basic_bus: got %0d diffs want 0", ev_diffs()); end
        n_checks++;
        if (obs_done != 14) begin n_errors++; $display("FAIL basic_done_cycle: got %0d want 14", obs_done); end
        n_checks++;
        if (obs_err !== 1'b0) begin n_errors++; $display("FAIL basic_err: got %b want 0", obs_err); end
        n_checks++;
        if (obs_busy != 13 || obs_after_busy !== 1'b0 || obs_after_done !== 1'b0) begin
            n_errors++; $display("FAIL basic_busy_done: got busy_cycles=%0d busy_after=%b done_after=%b want 13/0/0",
                                 obs_busy, obs_after_busy, obs_after_done);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[d + AW'(i)] !== DW'(32'hA0 + i)) bad++;
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL basic_dst_words: got %0d wrong words want 0", bad); end
        n_checks++;
        if (obs_we_wo_sel != 0) begin n_errors++; $display("FAIL basic_we_without_sel: got %0d want 0", obs_we_wo_sel); end
    endtask

    task automatic test_len_zero();
        model_copy(MEM_BASE + 'h80, MEM_BASE + 'h90, 0);
        do_transfer(MEM_BASE + 'h80, MEM_BASE + 'h90, 0, -1, '0, '0);
        n_checks++;
        if (obs_q.size() != 0) begin n_errors++; $display("FAIL zero_sel_count: got %0d want 0", obs_q.size()); end
        n_checks++;
        if (obs_done != 2) begin n_errors++; $display("FAIL zero_done_cycle: got %0d want 2", obs_done); end
        n_checks++;
        if (obs_busy != 1 || obs_err !== 1'b0) begin
            n_errors++; $display("FAIL zero_busy_err: got busy_cycles=%0d err=%b want 1/0", obs_busy, obs_err);
        end
    endtask

    task automatic test_trap();
        logic [AW-1:0] s = MEM_BASE + 'h100;
        logic [AW-1:0] d = HOLE_BASE - 1'b1;
        model_copy(s, d, 3);
        do_transfer(s, d, 3, -1, '0, '0);
        n_checks++;
        if (ev_diffs() != 0) begin n_errors++; $display("FAIL trap_bus: got %0d diffs want 0", ev_diffs()); end
        n_checks++;
        if (obs_q.size() != 4) begin n_errors++; $display("FAIL trap_third_not_read: got %0d sel cycles want 4", obs_q.size()); end
        n_checks++;
        if (obs_err !== 1'b1 || obs_done != 8) begin
            n_errors++; $display("FAIL trap_err_done: got err=%b done_cycle=%0d want 1/8", obs_err, obs_done);
        end
        n_checks++;
        if (mem_diffs() != 0) begin n_errors++; $display("FAIL trap_memory: got %0d diffs want 0", mem_diffs()); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL trap_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_ignored_start();
        logic [AW-1:0] s = MEM_BASE + 'h600;
        logic [AW-1:0] d = MEM_BASE + 'h680;
        int idle_bad;
        model_copy(s, d, 5);
        do_transfer(s, d, 5, 4, MEM_BASE + 'h20, 2);
        n_checks++;
        if (ev_diffs() != 0 || obs_done != 17) begin
            n_errors++; $display("FAIL midstart_ignored: got diffs=%0d done_cycle=%0d want 0/17", ev_diffs(), obs_done);
        end
        n_checks++;
        if (obs_err !== 1'b0) begin n_errors++; $display("FAIL start_clears_err: got %b want 0", obs_err); end
        // Start raised in the completion cycle must not launch a new copy.
        model_copy(s + 'h8, d + 'h8, 2);
        do_transfer(s + 'h8, d + 'h8, 2, 7, MEM_BASE + 'h30, 3);
        n_checks++;
        if (ev_diffs() != 0 || obs_done != 8) begin
            n_errors++; $display("FAIL finstart_transfer: got diffs=%0d done_cycle=%0d want 0/8", ev_diffs(), obs_done);
        end
        idle_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || bus.sel || done) idle_bad++;
        end
        n_checks++;
        if (idle_bad != 0 || obs_after_busy !== 1'b0) begin
            n_errors++; $display("FAIL finstart_ignored: got %0d active idle cycles want 0", idle_bad);
        end
        n_checks++;
        if (mem_diffs() != 0) begin n_errors++; $display("FAIL ignored_memory: got %0d diffs want 0", mem_diffs()); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] s = AW'(MEM_WORDS - 2);
        logic [AW-1:0] a0, a1, a2;
        model_copy(s, MEM_BASE + 'h200, 3);
        do_transfer(s, MEM_BASE + 'h200, 3, -1, '0, '0);
        a0 = 'x; a1 = 'x; a2 = 'x;
        if (obs_q.size() >= 5) begin a0 = obs_q[0].addr; a1 = obs_q[2].addr; a2 = obs_q[4].addr; end
        n_checks++;
        if (a0 !== 13'h1FFE || a1 !== 13'h1FFF || a2 !== 13'h0000) begin
            n_errors++; $display("FAIL wrap_read_addrs: got %h %h %h want 1ffe 1fff 0000", a0, a1, a2);
        end
        n_checks++;
        if (ev_diffs() != 0 || obs_err !== 1'b0 || obs_done != 11) begin
            n_errors++; $display("FAIL wrap_transfer: got diffs=%0d err=%b done_cycle=%0d want 0/0/11",
                                 ev_diffs(), obs_err, obs_done);
        end
        n_checks++;
        if (mem_diffs() != 0) begin n_errors++; $display("FAIL wrap_memory: got %0d diffs want 0", mem_diffs()); end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] s = MEM_BASE + 'h300;
        logic [AW-1:0] d = MEM_BASE + 'h500;
        int act;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = 4;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);     // now in cycle 5: capture of word 2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({bus.sel, bus.we, busy, done, err} !== 5'b00000) begin
            n_errors++; $display("FAIL midreset_outputs: got sel/we/busy/done/err=%b want 00000",
                                 {bus.sel, bus.we, busy, done, err});
        end
        act = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || bus.sel || busy) act++;
        end
        n_checks++;
        if (act != 0) begin n_errors++; $display("FAIL midreset_discarded: got %0d active cycles want 0", act); end
        model_copy(s, d, 1);           // only the first word reached memory
        model_copy(MEM_BASE + 'h310, MEM_BASE + 'h510, 1);
        do_transfer(MEM_BASE + 'h310, MEM_BASE + 'h510, 1, -1, '0, '0);
        n_checks++;
        if (ev_diffs() != 0 || obs_done != 5 || obs_err !== 1'b0) begin
            n_errors++; $display("FAIL midreset_restart: got diffs=%0d done_cycle=%0d err=%b want 0/5/0",
                                 ev_diffs(), obs_done, obs_err);
        end
        n_checks++;
        if (mem_diffs() != 0) begin n_errors++; $display("FAIL midreset_memory: got %0d diffs want 0", mem_diffs()); end
    endtask

    task automatic test_max_len();
        model_copy(MEM_BASE, MEM_BASE + 'h400, '1);
        do_transfer(MEM_BASE, MEM_BASE + 'h400, '1, -1, '0, '0);
        n_checks++;
        if (ev_diffs() != 0 || obs_done != 3 * 1023 + 2 || obs_err !== 1'b0) begin
            n_errors++; $display("FAIL maxlen_transfer: got diffs=%0d done_cycle=%0d err=%b want 0/3071/0",
                                 ev_diffs(), obs_done, obs_err);
        end
        n_checks++;
        if (mem_diffs() != 0) begin n_errors++; $display("FAIL maxlen_memory: got %0d diffs want 0", mem_diffs()); end
    endtask

    task automatic test_random();
        logic [AW-1:0] s, d;
        logic [LW-1:0] n;
        for (int it = 0; it < 25; it++) begin
            s = AW'($urandom_range(0, MEM_WORDS - 1));
            d = AW'($urandom_range(0, MEM_WORDS - 1));
            n = LW'($urandom_range(0, 12));
            model_copy(s, d, n);
            do_transfer(s, d, n, -1, '0, '0);
            n_checks++;
            if (ev_diffs() != 0) begin
                n_errors++; $display("FAIL rand%0d_bus: got %0d diffs want 0 (src=%h dst=%h len=%0d)", it, ev_diffs(), s, d, n);
            end
            n_checks++;
            if (obs_done != exp_done || obs_err !== exp_err) begin
                n_errors++; $display("FAIL rand%0d_done_err: got cycle=%0d err=%b want %0d/%b",
                                     it, obs_done, obs_err, exp_done, exp_err);
            end
        end
        n_checks++;
        if (mem_diffs() != 0) begin n_errors++; $display("FAIL rand_memory: got %0d diffs want 0", mem_diffs()); end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = DW'($urandom);
        test_reset();
        sync_mem();
        test_basic();
        test_len_zero();
        test_trap();
        test_ignored_start();
        test_wrap();
        test_reset_mid();
        test_max_len();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
